// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - RV32M divide decode constants, FSM encodings and latched op context
package ex_div_pkg;

    localparam int INSTR_WIDTH   = 32;
    localparam int REG_IDX_WIDTH = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_CALC = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    typedef struct packed {
        logic quo_neg;
        logic rem_neg;
        logic is_rem;
        logic div0;
        logic ovf;
    } div_ctx_t;

endpackage

// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - ID/EX operand bundle into the divider and result/stall bundle back out
interface ex_div_if #(
    parameter int XLEN = 32
);
    import ex_div_pkg::*;

    logic [INSTR_WIDTH-1:0]   id_ex_instr;
    logic [XLEN-1:0]          id_ex_rs1_rdata;
    logic [XLEN-1:0]          id_ex_rs2_rdata;
    logic [REG_IDX_WIDTH-1:0] id_ex_rd_idx;
    logic                     div_stall;
    logic                     div_valid;
    logic [XLEN-1:0]          div_result;
    logic [REG_IDX_WIDTH-1:0] div_rd_idx;

    modport master (
        output id_ex_instr, id_ex_rs1_rdata, id_ex_rs2_rdata, id_ex_rd_idx,
        input  div_stall, div_valid, div_result, div_rd_idx
    );

    modport slave (
        input  id_ex_instr, id_ex_rs1_rdata, id_ex_rs2_rdata, id_ex_rd_idx,
        output div_stall, div_valid, div_result, div_rd_idx
    );
endinterface

// File: rtl/ex_div_iter.sv
// rtl/ex_div_iter.sv - radix-2 restoring shift-subtract datapath on unsigned magnitudes
module ex_div_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            run_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    trial;

    always_comb begin
        rem_sh = {rem_q, quo_q[XLEN-1]};
        // One extra bit so the borrow out of the trial subtract is the sign.
        trial  = rem_sh - {1'b0, dvs_q};
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        if (start_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = run_i && (cnt_q == CNT_W'(XLEN - 1));
    assign quo_o  = quo_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/ex_div.sv
// rtl/ex_div.sv - EX-stage iterative RV32M divider; RISCX_DIV_EARLY_OUT_EN skips iterations for div-by-zero/overflow
module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush_i,
    ex_div_if.slave  bus
);
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_instr_bits;

    assign opcode            = bus.id_ex_instr[6:0];
    assign funct3            = bus.id_ex_instr[14:12];
    assign funct7            = bus.id_ex_instr[31:25];
    assign unused_instr_bits = ^{bus.id_ex_instr[24:15], bus.id_ex_instr[11:7]};

    logic            is_div, op_signed, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] a, b, a_mag, b_mag;

    always_comb begin
        a         = bus.id_ex_rs1_rdata;
        b         = bus.id_ex_rs2_rdata;
        is_div    = (opcode == OPC_OP) && (funct7 == F7_MULDIV) && funct3[2];
        op_signed = (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg     = op_signed && a[XLEN-1];
        b_neg     = op_signed && b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        div0      = (b == '0);
        ovf       = op_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end

    logic [1:0]               state_q, state_d;
    div_ctx_t                 ctx_q, ctx_d;
    logic [XLEN-1:0]          dividend_q, dividend_d;
    logic [REG_IDX_WIDTH-1:0] rd_q, rd_d;
    logic [XLEN-1:0]          res_hold_q, res_hold_d;
    logic [REG_IDX_WIDTH-1:0] rd_hold_q, rd_hold_d;
    logic                     start, run, iter_done;
    logic [XLEN-1:0]          iter_quo, iter_rem;

    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        dividend_d = dividend_q;
        rd_d       = rd_q;
        start      = 1'b0;
        run        = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (is_div && !flush_i) begin
                    start      = 1'b1;
                    dividend_d = a;
                    rd_d       = bus.id_ex_rd_idx;
                    ctx_d      = '{quo_neg: a_neg ^ b_neg, rem_neg: a_neg,
                                   is_rem: funct3[1], div0: div0, ovf: ovf};
`ifdef RISCX_DIV_EARLY_OUT_EN
                    state_d    = (div0 || ovf) ? DIV_DONE : DIV_CALC;
`else
                    state_d    = DIV_CALC;
`endif
                end
            end
            DIV_CALC: begin
                run = !flush_i;
                if (iter_done) state_d = DIV_DONE;
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush_i) state_d = DIV_IDLE;
    end

    ex_div_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .run_i      (run),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (iter_done),
        .quo_o      (iter_quo),
        .rem_o      (iter_rem)
    );

    logic [XLEN-1:0] quo_fix, rem_fix, result_now;
    logic            fire;

    // Special cases override whatever the iterator left behind.
    always_comb begin
        quo_fix = ctx_q.quo_neg ? -iter_quo : iter_quo;
        rem_fix = ctx_q.rem_neg ? -iter_rem : iter_rem;
        if (ctx_q.div0) begin
            quo_fix = '1;
            rem_fix = dividend_q;
        end else if (ctx_q.ovf) begin
            quo_fix = dividend_q;
            rem_fix = '0;
        end
        result_now = ctx_q.is_rem ? rem_fix : quo_fix;
        fire       = (state_q == DIV_DONE) && !flush_i;
        res_hold_d = fire ? result_now : res_hold_q;
        rd_hold_d  = fire ? rd_q : rd_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DIV_IDLE;
            ctx_q      <= '0;
            dividend_q <= '0;
            rd_q       <= '0;
            res_hold_q <= '0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            dividend_q <= dividend_d;
            rd_q       <= rd_d;
            res_hold_q <= res_hold_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    always_comb begin
        bus.div_stall = 1'b0;
        case (state_q)
            DIV_IDLE: bus.div_stall = is_div && !flush_i;
            DIV_CALC: bus.div_stall = !flush_i;
            default:  bus.div_stall = 1'b0;
        endcase
        if (!rst_n) bus.div_stall = 1'b0;
    end

    assign bus.div_valid  = fire;
    assign bus.div_result = fire ? result_now : res_hold_q;
    assign bus.div_rd_idx = fire ? rd_q : rd_hold_q;

endmodule
